// File: rtl/instr_encoder_loader.sv
// Program loader: packs decoded instruction fields into 32-bit words and writes them
// sequentially into instruction memory. Optional running XOR via INSTR_ENC_CHECKSUM_EN.
module instr_encoder_loader #(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              restart,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [5:0]        in_op,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_target,
  input  logic              in_last,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [ADDR_W:0]   word_count,
  output logic              busy,
  output logic              done,
  output logic              err_illegal,
  output logic              err_full
`ifdef INSTR_ENC_CHECKSUM_EN
  , output logic [31:0]     checksum
`endif
);

  localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W:0]   LAST_CNT = {1'b0, {ADDR_W{1'b1}}};  // DEPTH-1

  typedef enum logic [1:0] {IDLE, ENC, WR, DONE} state_t;

  typedef struct packed {
    logic [5:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [15:0] imm;
    logic [25:0] target;
    logic        last;
  } bundle_t;

  state_t  state, state_n;
  bundle_t bun;
  logic [31:0] enc_word;
  logic        illegal;

  assign illegal = (bun.op > 6'd11);

  always_comb begin
    unique case (bun.op)
      6'd0:       enc_word = {bun.op, bun.rs, bun.rt, bun.rd, 11'b0};
      6'd2, 6'd3: enc_word = {bun.op, bun.target};
      default:    enc_word = {bun.op, bun.rs, bun.rt, bun.imm};
    endcase
  end

  always_comb begin
    state_n  = state;
    in_ready = 1'b0;
    mem_we   = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_n = ENC;
      end
      ENC: begin
        busy = 1'b1;
        if (illegal) state_n = bun.last ? DONE : IDLE;
        else         state_n = WR;
      end
      WR: begin
        busy   = 1'b1;
        mem_we = 1'b1;
        // the write in flight is the last slot of memory when count is DEPTH-1
        if (bun.last || word_count == LAST_CNT) state_n = DONE;
        else                                    state_n = IDLE;
      end
      default: done = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      bun         <= '0;
      mem_addr    <= BASE;
      mem_wdata   <= '0;
      word_count  <= '0;
      err_illegal <= 1'b0;
      err_full    <= 1'b0;
`ifdef INSTR_ENC_CHECKSUM_EN
      checksum    <= '0;
`endif
    end else if (restart) begin
      state       <= IDLE;
      mem_addr    <= BASE;
      mem_wdata   <= '0;
      word_count  <= '0;
      err_illegal <= 1'b0;
      err_full    <= 1'b0;
`ifdef INSTR_ENC_CHECKSUM_EN
      checksum    <= '0;
`endif
    end else begin
      state <= state_n;
      case (state)
        IDLE: if (in_valid) bun <= {in_op, in_rs, in_rt, in_rd, in_imm, in_target, in_last};
        ENC: begin
          if (illegal) err_illegal <= 1'b1;
          else         mem_wdata   <= enc_word;
        end
        WR: begin
          mem_addr   <= mem_addr + 1'b1;
          word_count <= word_count + 1'b1;
          if (!bun.last && word_count == LAST_CNT) err_full <= 1'b1;
`ifdef INSTR_ENC_CHECKSUM_EN
          checksum   <= checksum ^ mem_wdata;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Bench for instr_encoder_loader (DEPTH=4): directed latency/reset/full cases plus
// random programs scored against a field-level encoding model.
module tb_instr_encoder_loader;
  localparam int AW = 2;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic reset, restart, in_valid, in_ready, in_last;
  logic [5:0] in_op;
  logic [4:0] in_rs, in_rt, in_rd;
  logic [15:0] in_imm;
  logic [25:0] in_target;
  logic mem_we, busy, done, err_illegal, err_full;
  logic [AW-1:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [AW:0] word_count;
`ifdef INSTR_ENC_CHECKSUM_EN
  logic [31:0] checksum;
`endif

  instr_encoder_loader #(.ADDR_W(AW), .BASE_ADDR(0)) dut (
    .clk(clk), .reset(reset), .restart(restart),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_rs(in_rs),
    .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm), .in_target(in_target),
    .in_last(in_last), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .word_count(word_count), .busy(busy), .done(done),
    .err_illegal(err_illegal), .err_full(err_full)
`ifdef INSTR_ENC_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  op;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
    logic [25:0] tg;
    bit          last;
  } ins_t;

  int total = 0;
  int bad = 0;
  int got_a[$];
  logic [31:0] got_d[$];
  ins_t prog[$];

  always @(negedge clk)
    if (mem_we === 1'b1) begin
      got_a.push_back(int'(mem_addr));
      got_d.push_back(mem_wdata);
    end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_enc(input ins_t i);
    logic [31:0] w;
    w = 32'(i.op) * 32'h0400_0000;
    if (i.op == 6'd0)
      w = w + 32'(i.rs) * 32'h20_0000 + 32'(i.rt) * 32'h1_0000 + 32'(i.rd) * 32'h800;
    else if (i.op == 6'd2 || i.op == 6'd3)
      w = w + 32'(i.tg);
    else
      w = w + 32'(i.rs) * 32'h20_0000 + 32'(i.rt) * 32'h1_0000 + 32'(i.imm);
    return w;
  endfunction

  function automatic ins_t mk(input int op, input int rs, input int rt, input int rd,
                              input int imm, input int tg, input bit last);
    ins_t i;
    i.op = 6'(op); i.rs = 5'(rs); i.rt = 5'(rt); i.rd = 5'(rd);
    i.imm = 16'(imm); i.tg = 26'(tg); i.last = last;
    return i;
  endfunction

  task automatic send(input ins_t i);
    int t;
    @(negedge clk);
    in_valid = 1'b1; in_op = i.op; in_rs = i.rs; in_rt = i.rt; in_rd = i.rd;
    in_imm = i.imm; in_target = i.tg; in_last = i.last;
    t = 0;
    while (in_ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) chk("send_timeout", 1'b1, 1'b0);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic do_restart();
    @(negedge clk);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
  endtask

  task automatic run_prog(input string name);
    int t, cnt;
    bit ill, full;
    int ea[$];
    logic [31:0] ed[$];
    logic [31:0] x;
    do_restart();
    got_a.delete();
    got_d.delete();
    ill = 0; full = 0; cnt = 0; x = '0;
    foreach (prog[k]) begin
      if (prog[k].op > 6'd11) ill = 1;
      else begin
        ea.push_back(cnt);
        ed.push_back(model_enc(prog[k]));
        x = x ^ model_enc(prog[k]);
        cnt++;
        if (!prog[k].last && cnt == DEPTH) full = 1;
      end
    end
    foreach (prog[k]) send(prog[k]);
    t = 0;
    while (done !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk({name, "_done"}, done, 1'b1);
    chk({name, "_nwr"}, got_a.size(), ea.size());
    foreach (ea[k]) begin
      if (k < got_a.size()) begin
        chk({name, "_addr"}, got_a[k], ea[k]);
        chk({name, "_data"}, got_d[k], ed[k]);
      end
    end
    chk({name, "_cnt"}, word_count, cnt);
    chk({name, "_ill"}, err_illegal, ill);
    chk({name, "_full"}, err_full, full);
    chk({name, "_rdy"}, in_ready, 1'b0);
    chk({name, "_busy"}, busy, 1'b0);
`ifdef INSTR_ENC_CHECKSUM_EN
    chk({name, "_csum"}, checksum, x);
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, len;
    ins_t i;
    reset = 1'b1; restart = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    in_op = '0; in_rs = '0; in_rt = '0; in_rd = '0; in_imm = '0; in_target = '0;
    repeat (3) @(negedge clk);
    chk("rst_rdy", in_ready, 1'b1);
    chk("rst_we", mem_we, 1'b0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_cnt", word_count, 0);
    chk("rst_flags", {busy, done, err_illegal, err_full}, 4'b0);
    reset = 1'b0;

    // latency: accept at edge N, write during cycle N+2
    send(mk(0, 1, 2, 3, 0, 0, 0));
    @(negedge clk);
    chk("lat_enc_we", mem_we, 1'b0);
    chk("lat_enc_busy", busy, 1'b1);
    chk("lat_enc_rdy", in_ready, 1'b0);
    @(negedge clk);
    chk("lat_wr_we", mem_we, 1'b1);
    chk("lat_wr_addr", mem_addr, 0);
    chk("lat_wr_data", mem_wdata, 32'h0022_1800);
    @(negedge clk);
    chk("lat_rdy", in_ready, 1'b1);
    chk("lat_cnt", word_count, 1);

    prog.delete();
    prog.push_back(mk(7, 0, 4, 0, 5, 0, 0));
    prog.push_back(mk(3, 0, 0, 0, 0, 16, 1));
    run_prog("seq");
    if (got_d.size() == 2) begin
      chk("seq_w0", got_d[0], 32'h1C04_0005);
      chk("seq_w1", got_d[1], 32'h0C00_0010);
    end else chk("seq_len", got_d.size(), 2);

    prog.delete();
    prog.push_back(mk(12, 1, 1, 1, 1, 1, 0));
    prog.push_back(mk(4, 3, 5, 0, 16'h0040, 0, 1));
    run_prog("illegal");

    prog.delete();
    for (int k = 0; k < DEPTH; k++) prog.push_back(mk(1, k, k + 1, 0, k * 3, 0, 0));
    run_prog("full");

    do_restart();
    chk("rs_rdy", in_ready, 1'b1);
    chk("rs_cnt", word_count, 0);
    chk("rs_addr", mem_addr, 0);
    chk("rs_flags", {done, err_illegal, err_full, mem_we}, 4'b0);

    // reset during ENC of a legal op: no write may follow
    send(mk(10, 7, 8, 0, 16'hBEEF, 0, 0));
    #2 reset = 1'b1;
    #1;
    chk("arst_rdy", in_ready, 1'b1);
    chk("arst_we", mem_we, 1'b0);
    chk("arst_busy", busy, 1'b0);
    chk("arst_addr", mem_addr, 0);
    chk("arst_cnt", word_count, 0);
    n = got_a.size();
    repeat (3) @(negedge clk);
    chk("arst_nowr", got_a.size(), n);
    reset = 1'b0;

    for (int r = 0; r < 10; r++) begin
      prog.delete();
      len = $urandom_range(DEPTH, 1);
      for (int k = 0; k < len; k++) begin
        if ($urandom_range(3) == 0) i.op = 6'($urandom_range(63, 12));
        else                        i.op = 6'($urandom_range(11, 0));
        i.rs = 5'($urandom); i.rt = 5'($urandom); i.rd = 5'($urandom);
        i.imm = 16'($urandom); i.tg = 26'($urandom);
        i.last = (k == len - 1);
        prog.push_back(i);
      end
      run_prog("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
